// File: rtl/posit_pkg.sv
// Shared posit constants and types for the posit_packer slice.
package posit_pkg;

    localparam int unsigned POSIT_N_DEF  = 32;
    localparam int unsigned POSIT_ES_DEF = 3;

    localparam logic [POSIT_N_DEF-1:0] POSIT_MAXPOS = {1'b0, {(POSIT_N_DEF-1){1'b1}}};
    localparam logic [POSIT_N_DEF-1:0] POSIT_MINPOS = POSIT_N_DEF'(1);

    typedef logic signed [POSIT_N_DEF-1:0] regime_t;

endpackage

// File: rtl/posit_regime_gen.sv
// Regime decode: run length (including terminator), leading-bit polarity and
// saturation flags for a signed regime value k.
module posit_regime_gen #(
    parameter int unsigned N  = 32,
    parameter int unsigned LW = $clog2(N) + 1
) (
    input  logic signed [N-1:0] i_k,
    output logic [LW-1:0]       o_len,
    output logic                o_pol,
    output logic                o_sat_max,
    output logic                o_sat_min
);

    localparam logic signed [N-1:0] K_HI = N'(N - 2);
    localparam logic signed [N-1:0] K_LO = -K_HI;

    always_comb begin
        o_pol     = ~i_k[N-1];
        o_sat_max = (i_k >= K_HI);
        o_sat_min = (i_k < K_LO);
        // Only meaningful outside saturation, where the length fits in LW bits
        o_len     = o_pol ? (i_k[LW-1:0] + LW'(2)) : (LW'(1) - i_k[LW-1:0]);
    end

endmodule

// File: rtl/posit_packer.sv
// Packs regime/exponent/fraction into an N-bit posit with one register stage.
// Optional signed output when POSIT_PACKER_SIGN_EN is defined.
module posit_packer
    import posit_pkg::*;
#(
    parameter int unsigned N  = POSIT_N_DEF,
    parameter int unsigned ES = POSIT_ES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
`ifdef POSIT_PACKER_SIGN_EN
    input  logic                sign,
`endif
    input  logic signed [N-1:0] seed,
    input  logic [ES-1:0]       exp,
    input  logic [N-1:0]        frac,
    output logic [N-1:0]        posit,
    output logic                out_valid
);

    localparam int unsigned LW  = $clog2(N) + 1;
    localparam int unsigned PAD = N - 2 - ES;

    logic [LW-1:0]       w_len;
    logic                w_pol;
    logic                w_sat_max;
    logic                w_sat_min;
    logic [LW-1:0]       w_sh;
    logic signed [2*N-1:0] w_word;
    logic signed [2*N-1:0] w_shifted;
    logic [N-2:0]        w_body;
    logic [N-1:0]        w_pos;
    logic [N-1:0]        w_res;
    logic [N-1:0]        r_posit;
    logic                r_valid;

    posit_regime_gen #(
        .N  (N),
        .LW (LW)
    ) u_regime (
        .i_k       (seed),
        .o_len     (w_len),
        .o_pol     (w_pol),
        .o_sat_max (w_sat_max),
        .o_sat_min (w_sat_min)
    );

    always_comb begin
        // Seed word holds one regime bit plus terminator; the arithmetic shift
        // replicates the leading bit to extend the run to its full length.
        w_sh      = w_len - LW'(2);
        w_word    = {w_pol, ~w_pol, exp, frac, {PAD{1'b0}}};
        w_shifted = w_word >>> w_sh;
        if (w_sat_max) begin
            w_body = '1;
        end else if (w_sat_min) begin
            w_body = (N-1)'(1);
        end else begin
            w_body = (N-1)'(w_shifted >> (N + 1));
        end
        w_pos = {1'b0, w_body};
`ifdef POSIT_PACKER_SIGN_EN
        w_res = sign ? (-w_pos) : w_pos;
`else
        w_res = w_pos;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_posit <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_posit <= w_res;
            end
        end
    end

    assign posit     = r_posit;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_posit_packer.sv
// Directed + random scoreboard bench for posit_packer (N=32, ES=3).
module tb_posit_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        sign_i;
    logic [31:0] seed;
    logic [2:0]  exp_i;
    logic [31:0] frac;
    logic [31:0] posit;
    logic        out_valid;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [31:0] sb[$];
    logic [31:0] last_exp;

`ifdef POSIT_PACKER_SIGN_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    posit_packer #(
        .N  (32),
        .ES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef POSIT_PACKER_SIGN_EN
        .sign      (sign_i),
`endif
        .seed      (seed),
        .exp       (exp_i),
        .frac      (frac),
        .posit     (posit),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Bit-serial reference: emit regime, exponent and fraction MSB-first.
    function automatic logic [31:0] model(input int k, input logic [2:0] e,
                                          input logic [31:0] f, input bit s);
        logic [31:0] r;
        int p;
        r = '0;
        if (k >= 30) begin
            r = 32'h7FFFFFFF;
        end else if (k < -30) begin
            r = 32'h00000001;
        end else begin
            p = 30;
            if (k >= 0) begin
                for (int i = 0; i < k + 1; i++) begin
                    if (p >= 0) r[p] = 1'b1;
                    p--;
                end
                p--;
            end else begin
                p = p + k;
                if (p >= 0) r[p] = 1'b1;
                p--;
            end
            for (int i = 2; i >= 0; i--) begin
                if (p >= 0) r[p] = e[i];
                p--;
            end
            for (int i = 31; i >= 0; i--) begin
                if (p >= 0) r[p] = f[i];
                p--;
            end
        end
        if (s) r = -r;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input bit v, input int k, input logic [2:0] e,
                        input logic [31:0] f, input bit s, input logic [31:0] expv);
        logic [31:0] want;
        @(negedge clk);
        in_valid = v;
        seed     = 32'(k);
        exp_i    = e;
        frac     = f;
        sign_i   = s;
        if (v) sb.push_back(expv);
        @(posedge clk);
        #1;
        check({tag, "/valid"}, {31'd0, out_valid}, {31'd0, v});
        if (out_valid) begin
            if (sb.size() == 0) begin
                check({tag, "/sb_empty"}, posit, 32'hxxxxxxxx);
            end else begin
                want = sb.pop_front();
                check(tag, posit, want);
                last_exp = want;
            end
        end else begin
            check({tag, "/hold"}, posit, last_exp);
        end
    endtask

    function automatic logic [31:0] sgn(input bit s, input logic [31:0] c);
        return s ? -c : c;
    endfunction

    initial begin
        int k;
        logic [2:0] e;
        logic [31:0] f;
        bit s;

        clk      = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sign_i   = 1'b0;
        seed     = '0;
        exp_i    = '0;
        frac     = '0;
        n_cmp    = 0;
        n_err    = 0;
        last_exp = '0;

        #12;
        check("reset/posit", posit, 32'h0);
        check("reset/valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("k0",        1, 0,   3'd3, 32'd20,       0, 32'h4C000000);
        step("kneg3",     1, -3,  3'd7, 32'd4,        0, 32'h0F000000);
        step("k5",        1, 5,   3'd7, 32'd4,        0, 32'h7EE00000);
        step("k13",       1, 13,  3'd0, 32'hFFFFFFFF, 0, 32'h7FFE1FFF);
        step("kneg29",    1, -29, 3'd7, 32'd0,        0, 32'h00000003);
        step("sat30",     1, 30,  3'd5, 32'h12345678, 0, 32'h7FFFFFFF);
        step("sat40",     1, 40,  3'd0, 32'd0,        0, 32'h7FFFFFFF);
        step("satneg31",  1, -31, 3'd7, 32'hFFFFFFFF, 0, 32'h00000001);
        step("satneg40",  1, -40, 3'd2, 32'd0,        0, 32'h00000001);
        step("k29_full",  1, 29,  3'd7, 32'hFFFFFFFF, 0, 32'h7FFFFFFE);
        step("kneg30",    1, -30, 3'd7, 32'hFFFFFFFF, 0, 32'h00000001);
        step("idle",      0, 0,   3'd0, 32'd0,        0, 32'h0);
        step("idle2",     0, 7,   3'd1, 32'hDEADBEEF, 0, 32'h0);

        // back-to-back burst
        step("b2b_0", 1, -1, 3'd4, 32'h80000000, 0, model(-1, 3'd4, 32'h80000000, 0));
        step("b2b_1", 1, 2,  3'd1, 32'hC0000000, 0, model(2, 3'd1, 32'hC0000000, 0));
        step("b2b_2", 1, -7, 3'd6, 32'hA0000000, 0, model(-7, 3'd6, 32'hA0000000, 0));
        step("b2b_end", 0, 0, 3'd0, 32'd0, 0, 32'h0);

        if (SIGN_EN) begin
            step("sign_k0",  1, 0,  3'd3, 32'd20, 1, 32'hB4000000);
            step("sign_sat", 1, 40, 3'd3, 32'd20, 1, sgn(1'b1, 32'h7FFFFFFF));
        end

        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 70)) - 35;
            e = 3'($urandom_range(0, 7));
            f = $urandom();
            s = SIGN_EN ? bit'($urandom_range(0, 1)) : 1'b0;
            step("rand", 1, k, e, f, s, model(k, e, f, s));
        end

        // asynchronous reset while a result is pending
        step("pre_rst", 1, 7, 3'd5, 32'hA5A5A5A5, 0, model(7, 3'd5, 32'hA5A5A5A5, 0));
        @(negedge clk);
        in_valid = 1'b1;
        seed     = 32'd3;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async/posit", posit, 32'h0);
        check("rst_async/valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold/posit", posit, 32'h0);
        check("rst_hold/valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        last_exp = '0;
        step("post_rst_idle", 0, 0, 3'd0, 32'd0, 0, 32'h0);
        step("post_rst", 1, -2, 3'd2, 32'h40000000, 0, model(-2, 3'd2, 32'h40000000, 0));
        step("final_idle", 0, 0, 3'd0, 32'd0, 0, 32'h0);

        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/posit_packer.md
# posit_packer

- Packs decoded posit fields into one N-bit posit word:
  - regime value (`seed`), exponent (`exp`) and MSB-aligned fraction (`frac`).
- Sits at the back end of the posit arithmetic datapath, after normalisation, and produces the final encoded result.
- One registered output stage with a valid strobe.
- Rounding is truncation toward zero; out-of-range regimes saturate.

## Interface
- `N`, default 32: posit width in bits (≥ 8).
- `ES`, default 3: exponent field width in bits (1..N-3).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input fields valid this cycle.
- `seed` input N, signed two's complement: regime value k.
- `exp` input ES: unsigned exponent field.
- `frac` input N: fraction bits after the hidden bit, MSB-aligned (`frac[N-1]` is the first fraction bit).
- `posit` output N: registered packed posit.
- `out_valid` output 1: `posit` holds a new result.

## Operation
- Bit N-1 (sign) = 0, unless the sign macro is enabled (see Configuration).
- Regime field starts at bit N-2:
  - k ≥ 0: (k+1) ones followed by one zero.
  - k < 0: (−k) zeros followed by one one.
- After the regime come the ES exponent bits, MSB first, then `frac` bits from `frac[N-1]` downward.
- Concatenation is the regime pattern, then `exp`, then `frac`.
  - It is truncated after N-1 bits (bits N-2..0).
  - Excess low bits are discarded, with no rounding.
  - Partial exponent truncation is legal: keep the exponent MSBs that fit.
- Saturation:
  - k ≥ N-2 → maxpos, 0 followed by N-1 ones.
  - k < −(N-2) → minpos, 0…01.
  - The output is never 0 and never NaR from this block.
- k = N-3: regime fills exactly N-1 bits (ones then a zero); no exp/frac bits.
- k = −(N-2): regime fills exactly N-1 bits; result = minpos.

## Timing
- Reset (asynchronous assert, synchronous release): `posit` = 0, `out_valid` = 0.
- Latency 1 cycle: inputs sampled at edge t with `in_valid`=1 appear on `posit` after edge t, with `out_valid`=1 for exactly that cycle.
- Throughput: one result per cycle; back-to-back valids produce back-to-back results; no backpressure.
- `in_valid`=0: `posit` holds its last value; `out_valid`=0.
- Reset asserted mid-stream: pending result discarded; outputs go to reset values immediately.

## Configuration
- Macro `POSIT_PACKER_SIGN_EN`.
- Defined:
  - Adds input `sign` (1 bit), sampled with the other inputs.
  - When `sign`=1, output = two's complement of the packed positive posit (mod 2^N).
  - Saturated values are negated too.
- Undefined: no `sign` port; bit N-1 always 0.

## Structure
- Shared package `posit_pkg`:
  - Default `N`/`ES` constants.
  - Constants for maxpos/minpos patterns.
  - Typedef for the signed regime value.
- One natural sub-module, `posit_regime_gen` (combinational):
  - Takes k.
  - Returns regime length, the regime leading-bit polarity, and the saturation flags.
- Top module:
  - Builds the {regime, exp, frac} vector via a right shift of a 2N-bit word.
  - Applies saturation and optional negation.
  - Registers the result.

## Test plan
All cases use N=32, ES=3, with `in_valid`=1 for one cycle; check on the following cycle with `out_valid`=1.
- seed=0, exp=3, frac=20 → `posit`=0x4C000000 (regime "10", exp 011, frac low bits truncated).
- seed=−3, exp=7, frac=4 → 0x0F000000; seed=5, exp=7, frac=4 → 0x7EE00000.
- seed=13, exp=0, frac=0xFFFFFFFF → 0x7FFE1FFF; seed=−29, exp=7, frac=0 → 0x00000003 (exp truncated to 1 bit).
- Saturation:
  - seed=30 → 0x7FFFFFFF.
  - seed=40 → 0x7FFFFFFF.
  - seed=−31 → 0x00000001.
  - seed=−40 → 0x00000001.
- Handshake/reset:
  - Three back-to-back valids produce three consecutive `out_valid` pulses with matching results.
  - `rst_n` low mid-stream forces `posit`=0 and `out_valid`=0 asynchronously.
- With `POSIT_PACKER_SIGN_EN`: sign=1, seed=0, exp=3, frac=20 → 0xB4000000.
